// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the
// round-robin 4-to-2 encoder.
package encoder_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE,
        HOLD
    } state_e;

    function automatic logic [N_REQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of cand searching upward
// from ptr with wrap-around.
module rr_pick
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic [N_REQ-1:0] pick_oh,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        pick_idx = '0;
        any      = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Index arithmetic wraps naturally at IDX_W bits.
            idx = ptr + IDX_W'(i);
            if (!any && cand[idx]) begin
                any      = 1'b1;
                pick_idx = idx;
            end
        end
        pick_oh = any ? onehot_of(pick_idx) : '0;
    end

endmodule

// File: rtl/encoder_4x2_rr.sv
// Registered round-robin 4-to-2 encoder: sticky pending requests served one at
// a time as index + one-hot on a valid/ready handshake.
module encoder_4x2_rr
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] oh_q, oh_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic             any;
    logic             load;

    assign cand = pend_q | (en ? req : '0);

    rr_pick u_pick (
        .cand     (cand),
        .ptr      (ptr_q),
        .pick_idx (pick_idx),
        .pick_oh  (pick_oh),
        .any      (any)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = cand;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        valid_d = valid_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: load = any;
            HOLD: begin
                if (out_ready) begin
                    if (any) begin
                        load = 1'b1;
                    end else begin
                        // Drop valid but keep the last index visible.
                        valid_d = 1'b0;
                        oh_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
        endcase

        if (load) begin
            idx_d   = pick_idx;
            oh_d    = pick_oh;
            valid_d = 1'b1;
            pend_d  = cand & ~pick_oh;
            ptr_d   = pick_idx + IDX_W'(1);
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            valid_q <= valid_d;
        end
    end

    assign out_idx    = idx_q;
    assign out_onehot = oh_q;
    assign out_valid  = valid_q;
    assign busy       = (pend_q != '0) || valid_q;

endmodule

// File: tb/tb_encoder_4x2_rr.sv
// Self-checking bench for encoder_4x2_rr: directed scenarios plus randomized
// traffic against a behavioural round-robin model and a decoder loopback.
module tb_encoder_4x2_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       en = 1'b0;
    logic [1:0] out_idx;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit m_pend[4];
    int m_ptr;
    bit m_valid;
    int m_idx;

    encoder_4x2_rr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .en         (en),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; en = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        bit cand[4];
        int k;
        for (int i = 0; i < 4; i++) cand[i] = m_pend[i] | (en & req[i]);
        if (!m_valid || out_ready) begin
            k = -1;
            for (int i = 0; i < 4; i++)
                if (k < 0 && cand[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
            if (k >= 0) begin
                m_valid = 1; m_idx = k; cand[k] = 0; m_ptr = (k + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < 4; i++) m_pend[i] = cand[i];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_idx, out_onehot, busy} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%b idx=%0d oh=%b busy=%b, need all 0",
                     out_valid, out_idx, out_onehot, busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; en = 1'b1; out_ready = 1'b1;
        tick();
        req = '0;
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== 2'd2 || out_onehot !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: valid=%b idx=%0d oh=%b, need 1/2/0100",
                     out_valid, out_idx, out_onehot);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_onehot !== 4'b0 || out_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL single_drop: valid=%b busy=%b oh=%b idx=%0d, need 0/0/0000/2",
                     out_valid, busy, out_onehot, out_idx);
        end
    endtask

    task automatic test_all_held();
        do_reset();
        req = 4'b1111; en = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_idx !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL all_held[%0d]: valid=%b idx=%0d, need 1/%0d",
                         k, out_valid, out_idx, k % 4);
            end
        end
        req = '0;
        do_reset();
    endtask

    task automatic test_stall();
        do_reset();
        req = 4'b1010; en = 1'b1; out_ready = 1'b0;
        tick();
        req = '0;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_onehot !== 4'b0010) begin
                n_fail++;
                $display("FAIL stall[%0d]: valid=%b idx=%0d oh=%b, need 1/1/0010",
                         k, out_valid, out_idx, out_onehot);
            end
            if (k < 4) tick();
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== 2'd3 || out_onehot !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_next: valid=%b idx=%0d oh=%b, need 1/3/1000",
                     out_valid, out_idx, out_onehot);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: valid=%b busy=%b, need 0/0", out_valid, busy);
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; req = 4'b1111; out_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_block: valid=%b busy=%b, need 0/0", out_valid, busy);
        end
        // Two captured with en=1, second must drain while en=0.
        en = 1'b1; req = 4'b0011; out_ready = 1'b0;
        tick();
        en = 1'b0; req = 4'b1111;
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL en_first: valid=%b idx=%0d, need 1/0", out_valid, out_idx);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL en_drain: valid=%b idx=%0d, need 1/1", out_valid, out_idx);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_idle: valid=%b busy=%b, need 0/0", out_valid, busy);
        end
        req = '0;
    endtask

    task automatic test_rerequest();
        do_reset();
        req = 4'b0100; en = 1'b1; out_ready = 1'b0;
        tick();
        tick();          // re-pulse while index 2 is presented
        req = '0;
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rereq_hold: valid=%b idx=%0d busy=%b, need 1/2/1",
                     out_valid, out_idx, busy);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== 2'd2 || out_onehot !== 4'b0100) begin
            n_fail++;
            $display("FAIL rereq_again: valid=%b idx=%0d oh=%b, need 1/2/0100",
                     out_valid, out_idx, out_onehot);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rereq_end: valid=%b busy=%b, need 0/0", out_valid, busy);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0010; en = 1'b1; out_ready = 1'b0;
        tick();
        req = 4'b1001;
        tick();
        req = '0;
        n_tests++;
        if (out_valid !== 1'b1 || out_idx !== 2'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b idx=%0d busy=%b, need 1/1/1",
                     out_valid, out_idx, busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_idx, out_onehot, busy} !== 8'b0) begin
            n_fail++;
            $display("FAIL mid_async: valid=%b idx=%0d oh=%b busy=%b, need all 0",
                     out_valid, out_idx, out_onehot, busy);
        end
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lost: valid=%b busy=%b, need 0/0", out_valid, busy);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_oh;
        logic [3:0] dec;
        bit         m_busy;
        do_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_ptr = 0; m_valid = 0; m_idx = 0;
        for (int c = 0; c < 400; c++) begin
            req       = 4'($urandom);
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            model_step();
            tick();
            exp_oh = m_valid ? 4'(1 << m_idx) : 4'b0;
            m_busy = m_valid;
            for (int i = 0; i < 4; i++) m_busy |= m_pend[i];
            n_tests++;
            if (out_valid !== m_valid || out_idx !== 2'(m_idx) || out_onehot !== exp_oh
                || busy !== m_busy) begin
                n_fail++;
                $display("FAIL rand[%0d]: valid=%b idx=%0d oh=%b busy=%b, need %b/%0d/%b/%b",
                         c, out_valid, out_idx, out_onehot, busy,
                         m_valid, m_idx, exp_oh, m_busy);
            end
            // Loopback: 2-to-4 decoder enabled by out_valid
            dec = out_valid ? 4'(1 << out_idx) : 4'b0;
            n_tests++;
            if (dec !== out_onehot) begin
                n_fail++;
                $display("FAIL loopback[%0d]: oh=%b, decoder gives %b", c, out_onehot, dec);
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_held();
        test_stall();
        test_enable();
        test_rerequest();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_4x2_rr.md
# encoder_4x2_rr

Registered 4-to-2 encoder: the encoding side of the 2-to-4 decoder path. It captures up to four request lines into a sticky pending register and serves them in round-robin order. Each served request is presented as a 2-bit index plus its one-hot image on a valid/ready output handshake. It sits upstream of the decoder, so a decoder fed from `out_idx` reproduces `out_onehot`. This gives the pair a loopback check.

## Interface
- `N_REQ`, 4: number of request lines; fixed at 4 for this block.
- `IDX_W`, 2: index width, equal to clog2(N_REQ).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request lines; each bit is sampled every cycle while `en`=1.
- `en`  in  1  capture enable; `en`=0 blocks new requests, while already-pending requests still drain.
- `out_idx`  out  2  index of the served request.
- `out_onehot`  out  4  one-hot of `out_idx`; all zeros when `out_valid`=0.
- `out_valid`  out  1  `out_idx`/`out_onehot` hold a served request.
- `out_ready`  in  1  downstream accepts the request this cycle.
- `busy`  out  1  `pend`≠0 or `out_valid`=1.

## Operation
- Internal state:
  - `pend[3:0]`: sticky pending bits.
  - `ptr[1:0]`: round-robin start position.
  - FSM with states IDLE and HOLD.
- Capture: `cand = pend | (en ? req : 0)`.
- Pick: the first set bit of `cand`, searching upward from `ptr` with wrap-around (ptr, ptr+1, …, ptr+3 mod 4).
- IDLE:
  - If `cand`≠0, register the pick into `out_idx`/`out_onehot`, set `out_valid`, set `pend <= cand & ~pick`, set `ptr <= pick_idx+1` (mod 4), and go to HOLD.
  - Otherwise set `pend <= cand`.
- HOLD, `out_ready`=0:
  - Outputs stay stable.
  - `pend <= pend | (en ? req : 0)`; new requests accumulate and nothing is dropped.
- HOLD, `out_ready`=1 (transfer):
  - If `cand`≠0, load the next pick as in IDLE and stay in HOLD. This gives back-to-back transfers at 1 per cycle.
  - Otherwise clear `out_valid` and `out_onehot`, keep `out_idx`, and go to IDLE.
- Repeated requests: a bit that is served and re-asserted later becomes pending again. A request held high therefore produces repeated grants, interleaved fairly with the other lines.
- A request on the bit being presented while in HOLD is kept in `pend`; it is not merged with the current grant.
- `en` affects capture only. It never gates the handshake or the draining of `pend`.

## Timing
- Reset (async assert, sync release): `out_valid`=0, `out_idx`=0, `out_onehot`=0, `pend`=0, `ptr`=0, state IDLE, `busy`=0.
- Latency: a request sampled at edge N appears with `out_valid`=1 after edge N (combinational in → registered out, 1 cycle).
- Throughput: 1 grant per cycle while `out_ready`=1 and `cand`≠0.
- Handshake: once `out_valid` rises, `out_idx`/`out_onehot` are stable until the cycle `out_ready`=1. `out_valid` never drops without a transfer.
- `out_ready` in IDLE is ignored.
- Reset mid-operation clears `pend` and any presented grant; the lost requests are not recovered.
- Fairness bound: with all four lines held high, each index is granted exactly once in every 4 consecutive transfers.

## Structure
- Package `encoder_pkg`:
  - `N_REQ`, `IDX_W` constants.
  - State enum {IDLE, HOLD}.
  - `onehot_of(idx)` function.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `cand[3:0]`, `ptr[1:0]`.
  - Outputs: `pick_idx[1:0]`, `pick_oh[3:0]`, `any`.
- Top level: FSM, `pend`/`ptr`/output registers.

## Test plan
- Reset, then `req`=4'b0100 for 1 cycle with `en`=1, `out_ready`=1 → next cycle `out_idx`=2, `out_onehot`=4'b0100, `out_valid`=1; one cycle later `out_valid`=0, `busy`=0.
- `req`=4'b1111 held, `en`=1, `out_ready`=1 from reset → `out_idx` sequence 0,1,2,3,0,… with `out_valid` continuous.
- `req`=4'b1010 pulsed for 1 cycle, `out_ready`=0 for 5 cycles, then 1 → `out_idx`=1 stable throughout the stall, then 3 on the next cycle, then `out_valid`=0.
- `en`=0 with `req`=4'b1111 → `out_valid` stays 0, `busy`=0. Pulse `req`=4'b0001 with `en`=1, then set `en`=0 → `out_idx`=0 is still served.
- Stalled in HOLD on index 2 with `req`=4'b0100 re-pulsed → after the transfer, index 2 is granted again; no request is lost.
- Assert `rst_n`=0 during HOLD with `pend`=4'b1001 → all outputs go to 0 immediately; after release, no grant appears without new `req`.
- Loopback: drive a 2-to-4 decoder from `out_idx`, with its enable tied to `out_valid` → decoder output equals `out_onehot` on every cycle.
